// File: rtl/chip8_tone_sequencer.sv
// CHIP-8 sound timer with 60 Hz decrement and an enveloped square-wave tone
// delivered on the codec's sample-request handshake.
module chip8_tone_sequencer #(
  parameter int unsigned CLK_HZ            = 50_000_000,
  parameter int unsigned TICK_HZ           = 60,
  parameter int unsigned TONE_HALF_SAMPLES = 24,
  parameter logic [15:0] AMPLITUDE         = 16'h2000,
  parameter logic [15:0] RAMP_STEP         = 16'h0100
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        st_write,
  input  logic [7:0]  st_wdata,
  output logic [7:0]  st_value,
  input  logic        sample_req,
  output logic [15:0] audio_output,
  output logic        tone_active
);

  localparam int unsigned DIV   = CLK_HZ / TICK_HZ;
  localparam int unsigned DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int unsigned PH_W  = (TONE_HALF_SAMPLES > 1) ? $clog2(TONE_HALF_SAMPLES) : 1;
  localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(DIV - 1);
  localparam logic [PH_W-1:0]  PH_MAX  = PH_W'(TONE_HALF_SAMPLES - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RAMP_UP,
    S_TONE,
    S_RAMP_DOWN
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [DIV_W-1:0]  r_div;
  logic              w_tick;
  logic [7:0]        r_st;
  logic [15:0]       r_amp;
  logic [15:0]       w_amp_nxt;
  logic [16:0]       w_amp_sum;
  logic [PH_W-1:0]   r_phase;
  logic              r_pol;
  logic [15:0]       r_audio;
  logic              r_active;

  assign w_tick       = (r_div == DIV_MAX);
  assign w_amp_sum    = {1'b0, r_amp} + {1'b0, RAMP_STEP};
  assign st_value     = r_st;
  assign audio_output = r_audio;
  assign tone_active  = r_active;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_div <= '0;
      r_st  <= '0;
    end else begin
      r_div <= w_tick ? '0 : r_div + 1'b1;
      if (st_write)
        r_st <= st_wdata;
      else if (w_tick && (r_st != '0))
        r_st <= r_st - 1'b1;
    end
  end

  // Transitions watch the registered ST, so they land one cycle after ST changes.
  always_comb begin
    w_state_nxt = r_state;
    w_amp_nxt   = r_amp;
    case (r_state)
      S_IDLE: begin
        w_amp_nxt = '0;
        if (r_st != '0) w_state_nxt = S_RAMP_UP;
      end
      S_RAMP_UP: begin
        if (sample_req)
          w_amp_nxt = (w_amp_sum >= {1'b0, AMPLITUDE}) ? AMPLITUDE : w_amp_sum[15:0];
        if (r_st == '0)
          w_state_nxt = S_RAMP_DOWN;
        else if (w_amp_nxt == AMPLITUDE)
          w_state_nxt = S_TONE;
      end
      S_TONE: begin
        if (r_st == '0) w_state_nxt = S_RAMP_DOWN;
      end
      S_RAMP_DOWN: begin
        if (sample_req)
          w_amp_nxt = (r_amp <= RAMP_STEP) ? '0 : r_amp - RAMP_STEP;
        if (r_st != '0)
          w_state_nxt = S_RAMP_UP;
        else if (w_amp_nxt == '0)
          w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_amp_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state  <= S_IDLE;
      r_active <= 1'b0;
      r_amp    <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_active <= (w_state_nxt != S_IDLE);
      r_amp    <= w_amp_nxt;
    end
  end

  // Polarity is sampled before it toggles, so the wrap sample keeps the old sign.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_phase <= '0;
      r_pol   <= 1'b1;
      r_audio <= '0;
    end else if (r_state == S_IDLE) begin
      r_phase <= '0;
      r_pol   <= 1'b1;
      if (sample_req) r_audio <= '0;
    end else if (sample_req) begin
      r_audio <= r_pol ? w_amp_nxt : (~w_amp_nxt + 16'd1);
      if (r_phase == PH_MAX) begin
        r_phase <= '0;
        r_pol   <= ~r_pol;
      end else begin
        r_phase <= r_phase + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_chip8_tone_sequencer.sv
// Directed bench for chip8_tone_sequencer with a 10-cycle tick, 4-step ramp
// and 2-sample half period.
module tb_chip8_tone_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        st_write;
  logic [7:0]  st_wdata;
  logic [7:0]  st_value;
  logic        sample_req;
  logic [15:0] audio_output;
  logic        tone_active;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int k      = 0;

  always #5 clk = ~clk;

  chip8_tone_sequencer #(
    .CLK_HZ            (600),
    .TICK_HZ           (60),
    .TONE_HALF_SAMPLES (2),
    .AMPLITUDE         (16'h0400),
    .RAMP_STEP         (16'h0100)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .st_write     (st_write),
    .st_wdata     (st_wdata),
    .st_value     (st_value),
    .sample_req   (sample_req),
    .audio_output (audio_output),
    .tone_active  (tone_active)
  );

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
    cyc++;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  // One sample_req pulse, check the registered sample, then finish a 4-cycle slot.
  task automatic sample(input string tag, input logic [15:0] exp);
    sample_req = 1'b1;
    step();
    sample_req = 1'b0;
    check(tag, audio_output, exp);
    k++;
    steps(3);
  endtask

  task automatic write_st(input logic [7:0] v);
    st_write = 1'b1;
    st_wdata = v;
    step();
    st_write = 1'b0;
  endtask

  logic [15:0] exp_b [8];
  int wait_n;

  initial begin
    exp_b = '{16'h0100, 16'h0200, 16'hFD00, 16'hFC00,
              16'h0400, 16'h0400, 16'hFC00, 16'hFC00};
    reset      = 1'b0;
    st_write   = 1'b0;
    st_wdata   = '0;
    sample_req = 1'b0;
    steps(2);
    check("rst_st",    16'(st_value), 16'h0000);
    check("rst_audio", audio_output,  16'h0000);
    check("rst_active", 16'(tone_active), 16'h0000);

    // Release with a write of 3 landing on the first edge; ticks at cycles 10,20,30.
    reset    = 1'b1;
    st_write = 1'b1;
    st_wdata = 8'd3;
    cyc      = 0;
    step();
    st_write = 1'b0;
    check("st_load3",     16'(st_value), 16'h0003);
    check("active_lag0",  16'(tone_active), 16'h0000);
    step();
    check("active_rise",  16'(tone_active), 16'h0001);
    steps(7);
    check("st_pretick",   16'(st_value), 16'h0003);
    step();
    check("st_tick1",     16'(st_value), 16'h0002);
    steps(10);
    check("st_tick2",     16'(st_value), 16'h0001);
    steps(10);
    check("st_tick3",     16'(st_value), 16'h0000);
    steps(10);
    check("st_floor",     16'(st_value), 16'h0000);
    sample("idle_sample", 16'h0000);
    check("active_off_a", 16'(tone_active), 16'h0000);

    // Ramp up into tone, then let ST run out and ramp down.
    write_st(8'd5);
    step();
    k = 0;
    for (int i = 0; i < 8; i++) sample($sformatf("tone_s%0d", i), exp_b[i]);
    wait_n = 0;
    while (st_value != 8'd0 && wait_n < 200) begin
      step();
      wait_n++;
    end
    check("st_expire",    16'(st_value), 16'h0000);
    steps(2);
    check("active_rd",    16'(tone_active), 16'h0001);
    sample("rd_s0", 16'h0300);
    sample("rd_s1", 16'h0200);
    check("audio_hold",   audio_output, 16'h0200);
    sample("rd_s2", 16'hFF00);
    sample("rd_s3", 16'h0000);
    check("active_fall",  16'(tone_active), 16'h0000);
    sample("post_idle",   16'h0000);

    // Reload during ramp-down continues from the current magnitude.
    write_st(8'd5);
    step();
    k = 0;
    sample("c_s0", 16'h0100);
    sample("c_s1", 16'h0200);
    sample("c_s2", 16'hFD00);
    sample("c_s3", 16'hFC00);
    write_st(8'd0);
    step();
    check("c_active_rd", 16'(tone_active), 16'h0001);
    sample("c_rd0", 16'h0300);
    sample("c_rd1", 16'h0200);
    write_st(8'd2);
    step();
    sample("c_reload", 16'hFD00);
    check("c_active_ru", 16'(tone_active), 16'h0001);

    // Asynchronous reset mid-tone, then a write colliding with a tick.
    #2 reset = 1'b0;
    #1;
    check("arst_audio",  audio_output, 16'h0000);
    check("arst_active", 16'(tone_active), 16'h0000);
    check("arst_st",     16'(st_value), 16'h0000);
    @(negedge clk);
    reset    = 1'b1;
    st_write = 1'b1;
    st_wdata = 8'd4;
    cyc      = 0;
    step();
    st_write = 1'b0;
    check("d_load4",     16'(st_value), 16'h0004);
    steps(8);
    check("d_pretick",   16'(st_value), 16'h0004);
    st_write = 1'b1;
    st_wdata = 8'd7;
    step();
    st_write = 1'b0;
    check("d_write_wins", 16'(st_value), 16'h0007);
    steps(10);
    check("d_next_tick", 16'(st_value), 16'h0006);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/chip8_tone_sequencer.md
# chip8_tone_sequencer

Sequencer for the Chip8 audio datapath. It owns the CHIP-8 sound timer (ST): CPU writes, 60 Hz decrement, and readback. While ST is non-zero it produces a square-wave tone on the codec's sample-request handshake. A linear amplitude envelope ramps the tone on and off so the codec never sees clicks. It sits between the CPU register file and the sound controller: its sample feeds the codec's `audio_output`, and `tone_active` drives the controller's `is_on`.

## Interface
- `CLK_HZ`, 50_000_000, frequency of `clk` in Hz.
- `TICK_HZ`, 60, ST decrement rate in Hz.
- `TONE_HALF_SAMPLES`, 24, samples per half tone period (1 kHz at 48 kHz).
- `AMPLITUDE`, 16'h2000, full envelope magnitude, ≤ 16'h7FFF.
- `RAMP_STEP`, 16'h0100, envelope change per sample, > 0.
- `clk` in 1: single clock for all logic.
- `reset` in 1: asynchronous, active-low reset.
- `st_write` in 1: one-cycle strobe, load ST.
- `st_wdata` in 8: ST load value.
- `st_value` out 8: current ST, for CPU readback (Fx07-style reads).
- `sample_req` in 1: one-cycle pulse on `clk`; codec wants the next sample.
- `audio_output` out 16: two's-complement sample, registered.
- `tone_active` out 1: high whenever the state is not IDLE.

## Operation
- **Tick divider:** counter runs 0..`CLK_HZ/TICK_HZ`-1. `tick` fires for one cycle when the counter is at max, then the counter wraps to 0. The divider free-runs and is never cleared by writes.
- **ST update**, evaluated each cycle in priority order:
  - `st_write`: ST <= `st_wdata`. A write beats a simultaneous tick.
  - else `tick` and ST≠0: ST <= ST-1.
  - ST never wraps below 0.
- **Envelope FSM** (`amp` is 16 bits unsigned, `amp_next` is the updated value):
  - IDLE: `amp`=0, phase=0, polarity=+. If ST≠0, go to RAMP_UP.
  - RAMP_UP: each `sample_req`, `amp` <= min(`amp`+`RAMP_STEP`, `AMPLITUDE`). Go to TONE when `amp_next`==`AMPLITUDE`. If ST==0, go to RAMP_DOWN.
  - TONE: `amp` holds. If ST==0, go to RAMP_DOWN.
  - RAMP_DOWN: each `sample_req`, `amp` <= (`amp`≤`RAMP_STEP`) ? 0 : `amp`-`RAMP_STEP`. Go to IDLE when `amp_next`==0. If ST≠0 (reload), go to RAMP_UP and continue from the current `amp`.
  - ST-driven transitions take effect the cycle after ST changes. `amp` only moves on `sample_req`.
- **Tone phase** (outside IDLE), on each `sample_req`:
  - phase increments.
  - At `TONE_HALF_SAMPLES`-1, phase wraps to 0 and polarity toggles.
- **Sample:** `audio_output` <= polarity ? `amp_next` : (~`amp_next`+1). It updates only on `sample_req` and holds otherwise. In IDLE, a `sample_req` loads 0.
- `tone_active` = (state≠IDLE), registered with the state.

## Timing
- **Reset values (asynchronous):**
  - ST=0, `st_value`=0.
  - Divider=0.
  - State=IDLE, `amp`=0, phase=0, polarity=+.
  - `audio_output`=16'h0000, `tone_active`=0.
- Reset mid-tone stops output immediately, with no ramp-down.
- `st_value` reflects a write one cycle after `st_write`.
- A write of 0 during TONE enters RAMP_DOWN two cycles after the strobe.
- `audio_output` is valid one cycle after `sample_req` and is stable until the next `sample_req`.
- `sample_req` pulses are at least 2 cycles apart.
- **First-sample rule:** the first `sample_req` after leaving IDLE outputs +`RAMP_STEP` (phase 0, polarity +).
- **Ramp length:** RAMP_UP lasts ceil(`AMPLITUDE`/`RAMP_STEP`) samples.
- `sample_req` in the same cycle as an FSM transition is processed using the pre-transition state.

## Test plan
Bench parameters for all scenarios: `CLK_HZ`=600, `TICK_HZ`=60 (tick every 10 cycles), `AMPLITUDE`=16'h0400, `RAMP_STEP`=16'h0100, `TONE_HALF_SAMPLES`=2, `sample_req` every 4 cycles.

1. Assert `reset`=0 mid-run -> all outputs 0 and `tone_active`=0 asynchronously. After release, the first tick arrives 10 cycles later.
2. Write ST=3 -> `st_value` reads 3, 2, 1, 0 on successive ticks, then stays 0. `tone_active` rises 1 cycle after ST becomes non-zero.
3. Write ST=5, then read the first 8 samples -> 0x0100, 0x0200, 0xFD00, 0xFC00, 0x0400, 0x0400, 0xFC00, 0xFC00.
4. Let ST expire in TONE -> 4 samples step down in magnitude to 0 with polarity continuing. `tone_active` falls on the cycle after `amp` reaches 0, and later samples are 0x0000.
5. While in RAMP_DOWN at `amp`=0x0200, write ST=2 -> RAMP_UP resumes and the next magnitude is 0x0300, not 0x0100.
6. Issue `st_write` (value 7) in the same cycle as a tick with ST=4 -> ST=7, not 3.
